// File: rtl/wb_burst_ram.sv
// Wishbone B4 classic slave RAM with registered-feedback incrementing bursts,
// byte-lane writes and an error response for addresses outside the array.
module wb_burst_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int WORD_COUNT = 256
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [31:0]             wb_adr_i,
  input  logic [DATA_WIDTH-1:0]   wb_dat_i,
  output logic [DATA_WIDTH-1:0]   wb_dat_o,
  input  logic [DATA_WIDTH/8-1:0] wb_sel_i,
  input  logic                    wb_we_i,
  input  logic                    wb_cyc_i,
  input  logic                    wb_stb_i,
  input  logic [2:0]              wb_cti_i,
  input  logic [1:0]              wb_bte_i,
  output logic                    wb_ack_o,
  output logic                    wb_err_o,
  output logic                    wb_stall_o
);
  localparam int SEL_WIDTH = DATA_WIDTH / 8;
  localparam int ADR_LSB   = $clog2(SEL_WIDTH);
  localparam int AW        = (WORD_COUNT > 1) ? $clog2(WORD_COUNT) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACK   = 2'd1;
  localparam logic [1:0] BURST = 2'd2;

  localparam logic [2:0] CTI_INCR = 3'b010;

  // Beat address carries one extra bit so a linear burst runs past the top
  // word into error beats instead of wrapping back to word 0.
  localparam logic [AW:0] WORD_LIMIT  = (AW+1)'(WORD_COUNT);
  localparam logic [AW:0] ADR_ONE     = (AW+1)'(1);
  localparam logic [AW:0] WRAP4_MASK  = (AW+1)'(3);
  localparam logic [AW:0] WRAP8_MASK  = (AW+1)'(7);
  localparam logic [AW:0] WRAP16_MASK = (AW+1)'(15);

  logic [DATA_WIDTH-1:0] mem [WORD_COUNT];

  logic [1:0]    state;
  logic [AW:0]   beat_adr;
  logic          hi_bad;
  logic [AW:0]   adr_idx;
  logic          adr_hi;
  logic [AW:0]   wrap_mask;
  logic [AW:0]   next_adr;
  logic [AW:0]   rd_word;
  logic          rd_err;
  logic [AW-1:0] rd_idx;
  logic          burst_go;
  logic          wr_en;

  assign adr_idx = {1'b0, wb_adr_i[ADR_LSB +: AW]};
  assign adr_hi  = (wb_adr_i >> (ADR_LSB + AW)) != 32'd0;

  always_comb begin
    wrap_mask = '0;
    next_adr  = beat_adr;
    case (wb_bte_i)
      2'b01:   wrap_mask = WRAP4_MASK;
      2'b10:   wrap_mask = WRAP8_MASK;
      2'b11:   wrap_mask = WRAP16_MASK;
      default: wrap_mask = '0;
    endcase
    if (wrap_mask == '0)
      next_adr = beat_adr[AW] ? beat_adr : beat_adr + ADR_ONE;
    else
      next_adr = (beat_adr & ~wrap_mask) | ((beat_adr + ADR_ONE) & wrap_mask);
  end

  // Read address: the bus address when starting, the next beat inside a burst.
  assign rd_word  = (state == IDLE) ? adr_idx : next_adr;
  assign rd_err   = ((state == IDLE) ? adr_hi : hi_bad) || (rd_word >= WORD_LIMIT);
  assign rd_idx   = rd_err ? '0 : rd_word[AW-1:0];
  assign burst_go = wb_cyc_i && wb_stb_i && (wb_cti_i == CTI_INCR);
  assign wr_en    = !rst_i && (state != IDLE) && wb_ack_o && wb_cyc_i && wb_stb_i && wb_we_i;

  assign wb_stall_o = 1'b0;

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      for (int k = 0; k < SEL_WIDTH; k++) begin
        if (wb_sel_i[k])
          mem[beat_adr[AW-1:0]][8*k +: 8] <= wb_dat_i[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      beat_adr <= '0;
      hi_bad   <= 1'b0;
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (wb_cyc_i && wb_stb_i) begin
            beat_adr <= adr_idx;
            hi_bad   <= adr_hi;
            wb_ack_o <= !rd_err;
            wb_err_o <= rd_err;
            wb_dat_o <= mem[rd_idx];
            state    <= (wb_cti_i == CTI_INCR) ? BURST : ACK;
          end
        end
        BURST: begin
          if (burst_go) begin
            beat_adr <= next_adr;
            wb_ack_o <= !rd_err;
            wb_err_o <= rd_err;
            wb_dat_o <= mem[rd_idx];
          end else begin
            wb_ack_o <= 1'b0;
            wb_err_o <= 1'b0;
            state    <= IDLE;
          end
        end
        default: begin
          wb_ack_o <= 1'b0;
          wb_err_o <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_wb_burst_ram.sv
// Randomised Wishbone master for wb_burst_ram with an array reference model and a
// response scoreboard checked by an independent monitor.
module tb_wb_burst_ram;
  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic [31:0] adr = '0;
  logic [31:0] dat_i = '0;
  logic [31:0] dat_o;
  logic [3:0]  sel = '0;
  logic        we = 1'b0;
  logic        cyc = 1'b0;
  logic        stb = 1'b0;
  logic [2:0]  cti = '0;
  logic [1:0]  bte = '0;
  logic        ack;
  logic        err;
  logic        stall;

  typedef struct {
    bit          err;
    bit          chk;
    logic [31:0] dat;
    string       name;
  } exp_t;

  exp_t        expq[$];
  exp_t        mon_e;
  logic [31:0] mdl [256];
  logic [31:0] wdat [256];
  logic [3:0]  wsel [256];
  int          errors = 0;
  int          checks = 0;

  wb_burst_ram #(.DATA_WIDTH(32), .WORD_COUNT(256)) dut (
    .clk_i(clk), .rst_i(rst_i), .wb_adr_i(adr), .wb_dat_i(dat_i), .wb_dat_o(dat_o),
    .wb_sel_i(sel), .wb_we_i(we), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_cti_i(cti),
    .wb_bte_i(bte), .wb_ack_o(ack), .wb_err_o(err), .wb_stall_o(stall)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  // Word visited by beat i: linear counts up, wrap-N cycles inside the aligned N-word block.
  function automatic int beat_word(input int sw, input bit burst, input logic [1:0] bt, input int i);
    int n;
    if (!burst || bt == 2'b00) return sw + i;
    n = 2 << bt;
    return (sw - sw % n) + (sw % n + i) % n;
  endfunction

  always @(negedge clk) begin
    if (ack === 1'b1 || err === 1'b1) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_response: ack=%b err=%b with nothing outstanding", ack, err);
      end else begin
        mon_e = expq.pop_front();
        check({mon_e.name, "_ack"}, 32'(ack), 32'(!mon_e.err));
        check({mon_e.name, "_err"}, 32'(err), 32'(mon_e.err));
        if (mon_e.chk) check({mon_e.name, "_data"}, dat_o, mon_e.dat);
      end
    end
  end

  // One transaction of n beats; rst_beat >= 0 asserts reset while that beat is presented.
  task automatic xfer(input string nm, input logic [31:0] a, input bit w, input bit burst,
                      input logic [1:0] bt, input int n, input int rst_beat);
    int   sw;
    int   wd;
    int   lat;
    bit   hib;
    exp_t e;
    sw  = int'(a[9:2]);
    hib = (a[31:10] != 22'd0);
    @(posedge clk);
    #1;
    for (int i = 0; i < n; i++) begin
      wd    = beat_word(sw, burst, bt, i);
      e.err = hib || (wd > 255);
      e.chk = !w && !e.err;
      e.dat = e.chk ? mdl[wd] : 32'h0;
      e.name = nm;
      expq.push_back(e);
      if (w && !e.err && i != rst_beat) begin
        for (int k = 0; k < 4; k++)
          if (wsel[i][k]) mdl[wd][8*k +: 8] = wdat[i][8*k +: 8];
      end
      cyc   = 1'b1;
      stb   = 1'b1;
      adr   = (i == 0) ? a : $urandom;
      we    = w;
      bte   = bt;
      dat_i = wdat[i];
      sel   = wsel[i];
      cti   = !burst ? 3'b000 : ((i == n - 1) ? 3'b111 : 3'b010);
      if (i == rst_beat) rst_i = 1'b1;
      lat = 0;
      do begin
        @(negedge clk);
        lat++;
      end while (ack !== 1'b1 && err !== 1'b1 && lat < 6);
      check({nm, "_latency"}, 32'(lat), (i == 0) ? 32'd2 : 32'd1);
      if (ack !== 1'b1 && err !== 1'b1) begin
        expq.delete();
        break;
      end
      @(posedge clk);
      #1;
      if (i == rst_beat) break;
    end
    cyc   = 1'b0;
    stb   = 1'b0;
    we    = 1'b0;
    cti   = 3'b000;
    rst_i = 1'b0;
    @(negedge clk);
    check({nm, "_ack_after"}, 32'(ack), 32'd0);
    check({nm, "_err_after"}, 32'(err), 32'd0);
    if (rst_beat >= 0) check({nm, "_dat_reset"}, dat_o, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    int          kind;
    int          n;
    bit          w;
    logic [1:0]  bt;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ack", 32'(ack), 32'd0);
    check("reset_err", 32'(err), 32'd0);
    check("reset_dat", dat_o, 32'd0);
    check("reset_stall", 32'(stall), 32'd0);
    @(posedge clk);
    #1;
    rst_i = 1'b0;

    for (int i = 0; i < 256; i++) begin
      wdat[i] = $urandom;
      wsel[i] = 4'hF;
    end
    xfer("fill", 32'h0, 1'b1, 1'b1, 2'b00, 256, -1);

    wdat[0] = 32'hDEADBEEF; wsel[0] = 4'hF;
    xfer("t1_wr", 32'h10, 1'b1, 1'b0, 2'b00, 1, -1);
    xfer("t1_rd", 32'h10, 1'b0, 1'b0, 2'b00, 1, -1);

    wdat[0] = 32'hAABBCCDD; wsel[0] = 4'hF;
    xfer("t2_wr_full", 32'h20, 1'b1, 1'b0, 2'b00, 1, -1);
    wdat[0] = 32'h11223344; wsel[0] = 4'b0101;
    xfer("t2_wr_lanes", 32'h20, 1'b1, 1'b0, 2'b00, 1, -1);
    xfer("t2_rd", 32'h20, 1'b0, 1'b0, 2'b00, 1, -1);

    xfer("t3_lin_rd", 32'h40, 1'b0, 1'b1, 2'b00, 4, -1);

    for (int i = 0; i < 4; i++) begin
      wdat[i] = $urandom;
      wsel[i] = 4'hF;
    end
    xfer("t4_wrap_wr", 32'h18, 1'b1, 1'b1, 2'b01, 4, -1);
    xfer("t4_rd", 32'h10, 1'b0, 1'b1, 2'b00, 4, -1);

    xfer("t5_oor", 32'h400, 1'b0, 1'b0, 2'b00, 1, -1);
    xfer("t5_edge", 32'h3F8, 1'b0, 1'b1, 2'b00, 3, -1);

    for (int i = 0; i < 8; i++) begin
      wdat[i] = $urandom;
      wsel[i] = 4'hF;
    end
    xfer("t6_rst", 32'h80, 1'b1, 1'b1, 2'b00, 8, 2);
    xfer("t6_rd", 32'h80, 1'b0, 1'b1, 2'b00, 8, -1);

    for (int t = 0; t < 40; t++) begin
      kind = $urandom_range(0, 2);
      w    = 1'($urandom_range(0, 1));
      a    = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
      if (kind == 0 && $urandom_range(0, 7) == 0) a[31:10] = 22'($urandom_range(1, 7));
      for (int i = 0; i < 16; i++) begin
        wdat[i] = $urandom;
        wsel[i] = 4'($urandom_range(0, 15));
      end
      case (kind)
        0: xfer("rnd_single", a, w, 1'b0, 2'b00, 1, -1);
        1: begin
          n = $urandom_range(2, 8);
          xfer("rnd_linear", a, w, 1'b1, 2'b00, n, -1);
        end
        default: begin
          bt = 2'($urandom_range(1, 3));
          n  = $urandom_range(2, 2 << bt);
          xfer("rnd_wrap", a, w, 1'b1, bt, n, -1);
        end
      endcase
    end

    check("scoreboard_drained", 32'(expq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
